// File: rtl/seq_pkg.sv
// Shared defaults and elaboration-time helpers for the serial pattern detector.
package seq_pkg;

    localparam int          DEF_PAT_W   = 4;
    localparam logic [31:0] DEF_PATTERN = 32'b1011;
    localparam int          DEF_CNT_W   = 8;

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input logic [31:0] pat, input int w, input int i);
        return pat[w-1-i];
    endfunction

    // Failure function: longest proper prefix of the first k pattern bits
    // that is also a suffix of them.
    function automatic int fail_len(input logic [31:0] pat, input int w, input int k);
        int  res;
        logic ok;
        res = 0;
        for (int l = 1; l < k; l++) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
                if (pat_bit(pat, w, j) != pat_bit(pat, w, k - l + j)) ok = 1'b0;
            end
            if (ok) res = l;
        end
        return res;
    endfunction

    // Longest pattern prefix that is a suffix of (prefix mp followed by b).
    function automatic int next_len(input logic [31:0] pat, input int w, input int mp, input logic b);
        int  res;
        int  top;
        logic ok;
        res = 0;
        top = (mp + 1 > w) ? w : mp + 1;
        for (int l = 1; l <= top; l++) begin
            ok = (pat_bit(pat, w, l - 1) == b);
            for (int j = 0; j < l - 1; j++) begin
                if (pat_bit(pat, w, j) != pat_bit(pat, w, mp - l + 1 + j)) ok = 1'b0;
            end
            if (ok) res = l;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Serial-bit and match-status bundle between a front-end and the detector.
interface seq_detector_if
    import seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             en;
    logic             x;
    logic             overlap;
    logic             clr_cnt;
    logic             y;
    logic [CNT_W-1:0] count;
    logic             busy;

    modport master (output en, x, overlap, clr_cnt, input y, count, busy);
    modport slave  (input en, x, overlap, clr_cnt, output y, count, busy);
endinterface

// File: rtl/seq_next_len.sv
// Combinational next-matched-length lookup; transition tables are constants
// built at elaboration from the pattern.
module seq_next_len
    import seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    localparam int              MW      = $clog2(PAT_W + 1)
) (
    input  logic [MW-1:0] i_m,
    input  logic          i_b,
    input  logic          i_overlap,
    output logic [MW-1:0] o_m
);
    localparam logic [31:0] PAT32     = 32'(PATTERN);
    localparam int          FAIL_FULL = fail_len(PAT32, PAT_W, PAT_W);

    logic [MW-1:0] w_base;
    logic [MW-1:0] w_nxt0 [PAT_W+1];
    logic [MW-1:0] w_nxt1 [PAT_W+1];

    // Entry PAT_W is never selected (the base is always folded below PAT_W)
    // but keeps the table size matched to the index width.
    for (genvar g = 0; g <= PAT_W; g++) begin : g_len
        localparam int N0 = next_len(PAT32, PAT_W, g, 1'b0);
        localparam int N1 = next_len(PAT32, PAT_W, g, 1'b1);
        assign w_nxt0[g] = MW'(N0);
        assign w_nxt1[g] = MW'(N1);
    end

    // After a full match, restart from the failure length or from empty.
    always_comb begin
        w_base = i_m;
        if (i_m == MW'(PAT_W)) w_base = i_overlap ? MW'(FAIL_FULL) : '0;
    end

    assign o_m = i_b ? w_nxt1[w_base] : w_nxt0[w_base];

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector: matched-length register, registered match
// pulse and saturating match counter.
module seq_detector
    import seq_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               CNT_W   = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    seq_detector_if.slave sd
);
    localparam int MW = $clog2(PAT_W + 1);

    logic [MW-1:0]    r_m;
    logic             r_y;
    logic [CNT_W-1:0] r_count;
    logic [MW-1:0]    w_next;
    logic             w_match;

    seq_next_len #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_next (
        .i_m       (r_m),
        .i_b       (sd.x),
        .i_overlap (sd.overlap),
        .o_m       (w_next)
    );

    assign w_match = (w_next == MW'(PAT_W));

    // Matched length advances only on accepted bits.
    always_ff @(posedge clk) begin
        if (rst)        r_m <= '0;
        else if (sd.en) r_m <= w_next;
    end

    // Match pulse lasts one cycle per completing accepted bit.
    always_ff @(posedge clk) begin
        if (rst) r_y <= 1'b0;
        else     r_y <= sd.en & w_match;
    end

    // Saturating counter; clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst)                                     r_count <= '0;
        else if (sd.clr_cnt)                         r_count <= '0;
        else if (sd.en && w_match && r_count != '1)  r_count <= r_count + 1'b1;
    end

    assign sd.y     = r_y;
    assign sd.count = r_count;
    assign sd.busy  = (r_m != '0) && (r_m != MW'(PAT_W));

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: a vector table on the default 1011 build,
// plus hand-written sequences for counter saturation and the 1111 pattern.
module tb_seq_detector;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    seq_detector_if #(.CNT_W(8)) ifa ();
    seq_detector_if #(.CNT_W(2)) ifb ();
    seq_detector_if #(.CNT_W(8)) ifc ();

    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (.clk(clk), .rst(rst_a), .sd(ifa));
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (.clk(clk), .rst(rst_b), .sd(ifb));
    seq_detector #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(8)) dut_c (.clk(clk), .rst(rst_c), .sd(ifc));

    typedef struct {
        logic       rst, en, x, ov, clr;
        logic       y, busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, en, x, ov, clr, y, busy, input logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.x = x; v.ov = ov; v.clr = clr;
        v.y = y; v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step_b(input logic rst, en, x, clr);
        rst_b = rst; ifb.en = en; ifb.x = x; ifb.overlap = 1'b1; ifb.clr_cnt = clr;
        @(posedge clk); #1;
    endtask

    task automatic step_c(input logic rst, en, x, ov);
        rst_c = rst; ifc.en = en; ifc.x = x; ifc.overlap = ov; ifc.clr_cnt = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [12:0] sb;
        logic [12:0] yb;
        int          cexp [13];
        logic [9:0]  act, exp;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.en = 0; ifa.x = 0; ifa.overlap = 0; ifa.clr_cnt = 0;
        ifb.en = 0; ifb.x = 0; ifb.overlap = 0; ifb.clr_cnt = 0;
        ifc.en = 0; ifc.x = 0; ifc.overlap = 0; ifc.clr_cnt = 0;

        //                 rst en x ov clr  y busy cnt
        // reset
        vecs.push_back(mk(1, 0, 0, 1, 0,   0, 0, 0));
        // overlap=1, stream 1011011
        vecs.push_back(mk(0, 1, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0,   1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0,   0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0,   0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0,   1, 0, 2));
        // overlap=0, same stream
        vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0,   1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0,   0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0,   0, 1, 1));
        // gapped: 1, gap, 0, gap x3, 1, 1, then idle
        vecs.push_back(mk(1, 0, 0, 1, 0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0,   1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0,   0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0,   0, 0, 1));
        // clr_cnt alone clears count without touching y/busy
        vecs.push_back(mk(0, 0, 0, 1, 1,   0, 0, 0));
        // reset mid-pattern: 1,0,1, rst, 1
        vecs.push_back(mk(0, 1, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0,   0, 1, 0));

        foreach (vecs[i]) begin
            rst_a = vecs[i].rst; ifa.en = vecs[i].en; ifa.x = vecs[i].x;
            ifa.overlap = vecs[i].ov; ifa.clr_cnt = vecs[i].clr;
            @(posedge clk); #1;
            act = {ifa.y, ifa.busy, ifa.count};
            exp = {vecs[i].y, vecs[i].busy, vecs[i].cnt};
            check($sformatf("vec%0d {y,busy,count}", i), int'(act), int'(exp));
        end
        rst_a = 1'b1;

        // Counter saturation with CNT_W=2, overlap=1
        sb   = 13'b1011011011011;
        yb   = 13'b0001001001001;
        cexp = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        step_b(1, 0, 0, 0);
        check("sat reset count", int'(ifb.count), 0);
        for (int i = 0; i < 13; i++) begin
            step_b(0, 1, sb[12-i], 0);
            check($sformatf("sat bit%0d y", i), int'(ifb.y), int'(yb[12-i]));
            check($sformatf("sat bit%0d count", i), int'(ifb.count), cexp[i]);
        end
        step_b(0, 1, 0, 0);
        check("sat b14 count", int'(ifb.count), 3);
        step_b(0, 1, 1, 0);
        check("sat b15 y", int'(ifb.y), 0);
        step_b(0, 1, 1, 1);
        check("clr on match y", int'(ifb.y), 1);
        check("clr on match count", int'(ifb.count), 0);
        step_b(0, 0, 0, 0);
        check("after clr y", int'(ifb.y), 0);
        check("after clr count", int'(ifb.count), 0);
        rst_b = 1'b1;

        // Pattern 1111: overlap=1 then overlap=0, seven 1s each
        step_c(1, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step_c(0, 1, 1, 1);
            check($sformatf("ov1 bit%0d y", i), int'(ifc.y), (i >= 3) ? 1 : 0);
            check($sformatf("ov1 bit%0d count", i), int'(ifc.count), (i >= 3) ? i - 2 : 0);
            check($sformatf("ov1 bit%0d busy", i), int'(ifc.busy), (i < 3) ? 1 : 0);
        end
        step_c(0, 0, 1, 1);
        check("ov1 idle y", int'(ifc.y), 0);
        check("ov1 idle count", int'(ifc.count), 4);
        check("ov1 idle busy", int'(ifc.busy), 0);
        step_c(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step_c(0, 1, 1, 0);
            check($sformatf("ov0 bit%0d y", i), int'(ifc.y), (i == 3) ? 1 : 0);
        end
        check("ov0 final count", int'(ifc.count), 1);
        check("ov0 final busy", int'(ifc.busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
